// File: rtl/apb_serial_tx_pkg.sv
// Shared definitions for the APB serial transmitter: register indices,
// CTRL / IRQ bit positions and the serialiser state encoding.
package apb_serial_pkg;

    localparam int REG_STATUS   = 0;
    localparam int REG_CTRL     = 1;
    localparam int REG_TXDATA   = 2;
    localparam int REG_FRAME    = 3;
    localparam int REG_BAUD     = 4;
    localparam int REG_IRQ_CFG  = 5;
    localparam int REG_IRQ_STAT = 6;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PAR_EN   = 1;
    localparam int CTRL_PAR_ODD  = 2;
    localparam int CTRL_STOP2    = 3;
    localparam int CTRL_FIFO_CLR = 4;

    localparam int IRQ_DONE = 0;
    localparam int IRQ_LOW  = 1;
    localparam int IRQ_OVF  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/apb_serial_tx_fifo.sv
// Synchronous show-ahead TX FIFO with single-cycle clear.
// Latency: a push is visible on dout/count the cycle after the write edge.
// Backpressure: push while full is dropped; pop while empty is ignored.
module tx_fifo #(
    parameter int DATAWIDTH  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATAWIDTH-1:0]          din,
    input  logic                          pop,
    input  logic                          clr,
    output logic [DATAWIDTH-1:0]          dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATAWIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_serial_tx.sv
// APB-programmed serial transmitter: register file, TX FIFO and frame serialiser.
// Latency: push at edge k pops at k+1, tx_o falls at k+2; frames run back-to-back.
// Backpressure: none on APB (PREADY_o=1); pushes into a full FIFO are dropped and flag OVF.
module apb_serial_tx
    import apb_serial_pkg::*;
#(
    parameter int ADDRESSWIDTH = 3,
    parameter int DATAWIDTH    = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDRESSWIDTH-1:0] PADDR_i,
    input  logic [DATAWIDTH-1:0]    PWDATA_i,
    input  logic                    PWRITE_i,
    input  logic                    PSELx_i,
    input  logic                    PENABLE_i,
    output logic [DATAWIDTH-1:0]    PRDATA_o,
    output logic                    PREADY_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 wr_en;
    logic [DATAWIDTH-1:0] rd_val;

    logic [3:0]           ctrl_q;
    logic [4:0]           frame_q;
    logic [DATAWIDTH-1:0] baud_q;
    logic [2:0]           irq_mask_q;
    logic [7:0]           irq_thr_q;
    logic                 done_q;
    logic                 ovf_q;
    logic [2:0]           irq_stat;
    logic                 low;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clr;
    logic [DATAWIDTH-1:0] fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    tx_state_t            state_q;
    logic [DATAWIDTH-1:0] shift_q;
    logic [4:0]           nbits_q;
    logic [4:0]           bit_cnt_q;
    logic [DATAWIDTH-1:0] baud_cnt_q;
    logic [DATAWIDTH-1:0] baud_l_q;
    logic                 par_en_l_q;
    logic                 par_bit_q;
    logic                 stop2_l_q;
    logic                 stop_cnt_q;
    logic                 tick;
    logic                 last_stop;
    logic                 load;
    logic                 line_bit;
    logic [4:0]           eff_n;

    function automatic logic data_parity(input logic [DATAWIDTH-1:0] d, input logic [4:0] n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATAWIDTH; i++) begin
            if (i < int'(n)) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction

    assign wr_en     = PSELx_i && PENABLE_i && PWRITE_i;
    assign fifo_push = wr_en && (PADDR_i == ADDRESSWIDTH'(REG_TXDATA));
    assign fifo_clr  = wr_en && (PADDR_i == ADDRESSWIDTH'(REG_CTRL)) && PWDATA_i[CTRL_FIFO_CLR];
    assign PREADY_o  = 1'b1;

    tx_fifo #(
        .DATAWIDTH  (DATAWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (fifo_push),
        .din   (PWDATA_i),
        .pop   (fifo_pop),
        .clr   (fifo_clr),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign low = (32'(fifo_count) <= 32'(irq_thr_q));

    always_comb begin
        irq_stat           = '0;
        irq_stat[IRQ_DONE] = done_q;
        irq_stat[IRQ_LOW]  = low;
        irq_stat[IRQ_OVF]  = ovf_q;
    end

    always_comb begin
        rd_val = '0;
        case (PADDR_i)
            ADDRESSWIDTH'(REG_STATUS): begin
                rd_val[STAT_BUSY]  = (state_q != IDLE);
                rd_val[STAT_FULL]  = fifo_full;
                rd_val[STAT_EMPTY] = fifo_empty;
                rd_val[15:8]       = 8'(fifo_count);
            end
            ADDRESSWIDTH'(REG_CTRL):     rd_val[3:0]  = ctrl_q;
            ADDRESSWIDTH'(REG_FRAME):    rd_val[4:0]  = frame_q;
            ADDRESSWIDTH'(REG_BAUD):     rd_val       = baud_q;
            ADDRESSWIDTH'(REG_IRQ_CFG): begin
                rd_val[2:0]  = irq_mask_q;
                rd_val[15:8] = irq_thr_q;
            end
            ADDRESSWIDTH'(REG_IRQ_STAT): rd_val[2:0]  = irq_stat;
            default:                     rd_val       = '0;
        endcase
    end

    assign PRDATA_o = (PSELx_i && !PWRITE_i) ? rd_val : '0;

    // Register file; sticky bits give priority to a same-cycle set over W1C.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q     <= '0;
            frame_q    <= 5'd8;
            baud_q     <= '0;
            irq_mask_q <= '0;
            irq_thr_q  <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (PADDR_i)
                    ADDRESSWIDTH'(REG_CTRL):  ctrl_q  <= PWDATA_i[3:0];
                    ADDRESSWIDTH'(REG_FRAME): frame_q <= PWDATA_i[4:0];
                    ADDRESSWIDTH'(REG_BAUD):  baud_q  <= PWDATA_i;
                    ADDRESSWIDTH'(REG_IRQ_CFG): begin
                        irq_mask_q <= PWDATA_i[2:0];
                        irq_thr_q  <= PWDATA_i[15:8];
                    end
                    default: ;
                endcase
            end
            done_q <= last_stop || (done_q && !(wr_en && (PADDR_i == ADDRESSWIDTH'(REG_IRQ_STAT))
                                                && PWDATA_i[IRQ_DONE]));
            ovf_q  <= (fifo_push && fifo_full) || (ovf_q && !(wr_en && (PADDR_i == ADDRESSWIDTH'(REG_IRQ_STAT))
                                                && PWDATA_i[IRQ_OVF]));
            irq_o  <= |(irq_stat & irq_mask_q);
        end
    end

    always_comb begin
        eff_n = frame_q;
        if (frame_q == 5'd0 || int'(frame_q) > DATAWIDTH) begin
            eff_n = 5'(DATAWIDTH);
        end
    end

    assign tick      = (baud_cnt_q == baud_l_q);
    assign last_stop = (state_q == STOP) && tick && (!stop2_l_q || stop_cnt_q);
    assign load      = ((state_q == IDLE) || last_stop) && ctrl_q[CTRL_EN] && !fifo_empty;
    assign fifo_pop  = load;

    always_comb begin
        case (state_q)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shift_q[0];
            PARITY:  line_bit = par_bit_q;
            default: line_bit = 1'b1;
        endcase
    end

    // tx_o is registered from the state, so the line lags the FSM by one cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            nbits_q    <= 5'd8;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            baud_l_q   <= '0;
            par_en_l_q <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_l_q  <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_o       <= 1'b1;
        end else begin
            tx_o <= line_bit;
            if (load) begin
                state_q    <= START;
                shift_q    <= fifo_dout;
                nbits_q    <= eff_n;
                baud_l_q   <= baud_q;
                par_en_l_q <= ctrl_q[CTRL_PAR_EN];
                par_bit_q  <= data_parity(fifo_dout, eff_n) ^ ctrl_q[CTRL_PAR_ODD];
                stop2_l_q  <= ctrl_q[CTRL_STOP2];
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else if (state_q == IDLE) begin
                baud_cnt_q <= '0;
            end else if (!tick) begin
                baud_cnt_q <= baud_cnt_q + DATAWIDTH'(1);
            end else begin
                baud_cnt_q <= '0;
                case (state_q)
                    START: begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                    DATA: begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == nbits_q - 5'd1) begin
                            state_q    <= par_en_l_q ? PARITY : STOP;
                            stop_cnt_q <= 1'b0;
                        end
                    end
                    PARITY: begin
                        state_q    <= STOP;
                        stop_cnt_q <= 1'b0;
                    end
                    STOP: begin
                        if (stop2_l_q && !stop_cnt_q) begin
                            stop_cnt_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_serial_tx.sv
// Directed bench for apb_serial_tx: register access, frame shapes, FIFO limits,
// interrupts and asynchronous reset mid-frame.
module tb_apb_serial_tx;

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_CTRL     = 3'd1;
    localparam logic [2:0] A_TXDATA   = 3'd2;
    localparam logic [2:0] A_FRAME    = 3'd3;
    localparam logic [2:0] A_BAUD     = 3'd4;
    localparam logic [2:0] A_IRQ_CFG  = 3'd5;
    localparam logic [2:0] A_IRQ_STAT = 3'd6;
    localparam logic [2:0] A_RSVD     = 3'd7;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [2:0]  PADDR_i;
    logic [15:0] PWDATA_i;
    logic        PWRITE_i;
    logic        PSELx_i;
    logic        PENABLE_i;
    logic [15:0] PRDATA_o;
    logic        PREADY_o;
    logic        tx_o;
    logic        irq_o;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] rd;

    apb_serial_tx #(
        .ADDRESSWIDTH (3),
        .DATAWIDTH    (16),
        .FIFO_DEPTH   (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PADDR_i   (PADDR_i),
        .PWDATA_i  (PWDATA_i),
        .PWRITE_i  (PWRITE_i),
        .PSELx_i   (PSELx_i),
        .PENABLE_i (PENABLE_i),
        .PRDATA_o  (PRDATA_o),
        .PREADY_o  (PREADY_o),
        .tx_o      (tx_o),
        .irq_o     (irq_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge PCLK);
        PSELx_i   = 1'b1;
        PWRITE_i  = 1'b1;
        PADDR_i   = a;
        PWDATA_i  = d;
        PENABLE_i = 1'b0;
        @(negedge PCLK);
        PENABLE_i = 1'b1;
        @(posedge PCLK);
        #1;
        PSELx_i   = 1'b0;
        PENABLE_i = 1'b0;
        PWRITE_i  = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge PCLK);
        PSELx_i   = 1'b1;
        PWRITE_i  = 1'b0;
        PADDR_i   = a;
        PENABLE_i = 1'b0;
        @(negedge PCLK);
        PENABLE_i = 1'b1;
        #1;
        d = PRDATA_o;
        @(posedge PCLK);
        #1;
        PSELx_i   = 1'b0;
        PENABLE_i = 1'b0;
    endtask

    // bits[0] is the first bit on the line; every cycle of every bit is checked.
    task automatic check_frame(input logic [31:0] bits, input int len, input int per);
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge PCLK);
                chk($sformatf("txbit%0d", b), {31'b0, tx_o}, {31'b0, bits[b]});
            end
        end
    endtask

    task automatic push_check(input logic [15:0] d, input logic [31:0] bits, input int len, input int per);
        apb_write(A_TXDATA, d);
        @(negedge PCLK);
        chk("lat_idle0", {31'b0, tx_o}, 32'd1);
        @(negedge PCLK);
        chk("lat_idle1", {31'b0, tx_o}, 32'd1);
        check_frame(bits, len, per);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal;
    end

    initial begin
        PRESETn   = 1'b0;
        PADDR_i   = '0;
        PWDATA_i  = '0;
        PWRITE_i  = 1'b0;
        PSELx_i   = 1'b0;
        PENABLE_i = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_tx", {31'b0, tx_o}, 32'd1);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // Reset state
        chk("rst_tx_rel", {31'b0, tx_o}, 32'd1);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_prdata", {16'b0, PRDATA_o}, 32'd0);
        chk("rst_pready", {31'b0, PREADY_o}, 32'd1);
        apb_read(A_STATUS, rd);   chk("rst_status", {16'b0, rd}, 32'h0004);
        apb_read(A_CTRL, rd);     chk("rst_ctrl", {16'b0, rd}, 32'h0000);
        apb_read(A_TXDATA, rd);   chk("rst_txdata", {16'b0, rd}, 32'h0000);
        apb_read(A_FRAME, rd);    chk("rst_frame", {16'b0, rd}, 32'h0008);
        apb_read(A_BAUD, rd);     chk("rst_baud", {16'b0, rd}, 32'h0000);
        apb_read(A_IRQ_CFG, rd);  chk("rst_irqcfg", {16'b0, rd}, 32'h0000);
        apb_read(A_IRQ_STAT, rd); chk("rst_sticky", {16'b0, rd & 16'h0005}, 32'h0000);
        apb_read(A_RSVD, rd);     chk("rst_rsvd", {16'b0, rd}, 32'h0000);

        // 8N1, D=1: 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        apb_write(A_BAUD, 16'h0001);
        apb_write(A_CTRL, 16'h0001);
        push_check(16'h00A5, 32'h0000_034A, 10, 2);
        apb_read(A_IRQ_STAT, rd); chk("done_set", {16'b0, rd}, 32'h0003);
        apb_read(A_STATUS, rd);   chk("idle_status", {16'b0, rd}, 32'h0004);

        // Even then odd parity on 0x07 (three ones)
        apb_write(A_CTRL, 16'h0003);
        push_check(16'h0007, 32'h0000_060E, 11, 2);
        apb_write(A_CTRL, 16'h0007);
        push_check(16'h0007, 32'h0000_040E, 11, 2);

        // Overflow with EN=0 and OVF interrupt
        apb_write(A_CTRL, 16'h0000);
        apb_write(A_IRQ_STAT, 16'h0005);
        apb_write(A_IRQ_CFG, 16'h0004);
        for (int i = 0; i < 16; i++) begin
            apb_write(A_TXDATA, 16'(i));
        end
        apb_read(A_STATUS, rd); chk("full_status", {16'b0, rd}, 32'h1002);
        apb_read(A_IRQ_STAT, rd); chk("no_ovf_yet", {16'b0, rd}, 32'h0000);
        apb_write(A_TXDATA, 16'h0055);
        chk("ovf_irq_lag", {31'b0, irq_o}, 32'd0);
        @(posedge PCLK); #1;
        chk("ovf_irq", {31'b0, irq_o}, 32'd1);
        apb_read(A_STATUS, rd);   chk("ovf_status", {16'b0, rd}, 32'h1002);
        apb_read(A_IRQ_STAT, rd); chk("ovf_stat", {16'b0, rd}, 32'h0004);
        apb_write(A_IRQ_STAT, 16'h0004);
        chk("w1c_irq_lag", {31'b0, irq_o}, 32'd1);
        @(posedge PCLK); #1;
        chk("w1c_irq", {31'b0, irq_o}, 32'd0);
        apb_write(A_CTRL, 16'h0010);
        apb_read(A_STATUS, rd); chk("clr_status", {16'b0, rd}, 32'h0004);
        apb_read(A_CTRL, rd);   chk("clr_ctrl", {16'b0, rd}, 32'h0000);

        // 12 data bits, 2 stop bits: 0xFABC sends 0xABC only
        apb_write(A_FRAME, 16'h000C);
        apb_write(A_CTRL, 16'h0009);
        push_check(16'hFABC, 32'h0000_7578, 15, 2);
        @(negedge PCLK);
        chk("post12_idle", {31'b0, tx_o}, 32'd1);

        // Streaming with LOW interrupt, then reset mid-frame
        apb_write(A_CTRL, 16'h0000);
        apb_write(A_FRAME, 16'h0008);
        apb_write(A_IRQ_CFG, 16'h0102);
        @(posedge PCLK); #1;
        chk("low_empty_irq", {31'b0, irq_o}, 32'd1);
        apb_write(A_TXDATA, 16'h00A5);
        apb_write(A_TXDATA, 16'h0007);
        apb_write(A_TXDATA, 16'h003C);
        chk("low_off_irq", {31'b0, irq_o}, 32'd0);
        apb_write(A_CTRL, 16'h0001);
        @(negedge PCLK);
        chk("en_idle0", {31'b0, tx_o}, 32'd1);
        @(negedge PCLK);
        chk("en_idle1", {31'b0, tx_o}, 32'd1);
        check_frame(32'h0000_034A, 10, 2);
        chk("low_irq_lag", {31'b0, irq_o}, 32'd0);
        check_frame(32'h0000_020E, 10, 2);
        chk("low_irq", {31'b0, irq_o}, 32'd1);
        @(negedge PCLK);
        chk("start3", {31'b0, tx_o}, 32'd0);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("rst_mid_tx", {31'b0, tx_o}, 32'd1);
        chk("rst_mid_irq", {31'b0, irq_o}, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        apb_read(A_STATUS, rd); chk("post_rst_status", {16'b0, rd}, 32'h0004);
        apb_read(A_CTRL, rd);   chk("post_rst_ctrl", {16'b0, rd}, 32'h0000);
        @(negedge PCLK);
        chk("post_rst_tx", {31'b0, tx_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
